// File: rtl/tm_pkg.sv
// Shared transactional-memory definitions: FSM state encoding, default widths
// and the saturating counter step. Also used by the TM_ALU stage.
package tm_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } tm_state_e;

  localparam int unsigned TM_LEN_W    = 8;
  localparam int unsigned TM_DROP_W   = 8;
  localparam int unsigned TM_SAT_STEP = 1;

endpackage : tm_pkg

// File: rtl/tm_sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Priority is clear, then load, then increment.
module tm_sat_counter
  import tm_pkg::*;
#(
  parameter int unsigned W = TM_LEN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (inc && cnt != MAX)  cnt <= cnt + W'(TM_SAT_STEP);
  end

endmodule : tm_sat_counter

// File: rtl/tm_tx_len_meter.sv
// Counts retired instructions inside each hardware transaction and hands the
// committed length to the statistics ALU through a one-entry valid/ready slot.
module tm_tx_len_meter
  import tm_pkg::*;
#(
  parameter int unsigned LEN_W  = TM_LEN_W,
  parameter int unsigned DROP_W = TM_DROP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_begin,
  input  logic              tx_commit,
  input  logic              tx_abort,
  input  logic              inst_retire,
  input  logic              len_ready,
  output logic [LEN_W-1:0]  CurTxLen,
  output logic              len_valid,
  output logic              in_tx,
  output logic              len_sat,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  tm_state_e        state_q, state_d;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_final;
  logic             commit_fire, end_fire, start_fire;
  logic             slot_free, drain, len_load, len_drop;

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_fire  = 1'b0;
    end_fire    = 1'b0;
    commit_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_begin) begin
          state_d    = ACTIVE;
          start_fire = 1'b1;
        end
      end
      ACTIVE: begin
        if (tx_abort || tx_commit) begin
          state_d     = IDLE;
          end_fire    = 1'b1;
          commit_fire = !tx_abort;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_tx = (state_q == ACTIVE);

  // Length counter: seeded on begin so a retire in the begin cycle counts.
  tm_sat_counter #(.W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (end_fire),
    .load     (start_fire),
    .load_val (LEN_W'(inst_retire)),
    .inc      (in_tx && inst_retire),
    .cnt      (cnt)
  );

  // Retirement in the commit cycle is folded in combinationally.
  assign len_final = (inst_retire && cnt != LEN_MAX) ? cnt + LEN_W'(TM_SAT_STEP) : cnt;

  assign drain     = len_valid && len_ready;
  assign slot_free = !len_valid || len_ready;
  assign len_load  = commit_fire && (len_final != '0) && slot_free;
  assign len_drop  = commit_fire && (len_final != '0) && !slot_free;

  // Output slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CurTxLen  <= '0;
      len_valid <= 1'b0;
      len_sat   <= 1'b0;
    end else begin
      if (len_load) begin
        CurTxLen  <= len_final;
        len_valid <= 1'b1;
        if (len_final == LEN_MAX) len_sat <= 1'b1;
      end else if (drain) begin
        len_valid <= 1'b0;
      end
    end
  end

  tm_sat_counter #(.W(DROP_W)) u_drop_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (len_drop),
    .cnt      (drop_cnt)
  );

endmodule : tm_tx_len_meter

// File: tb/tb_tm_tx_len_meter.sv
// Directed self-checking bench for tm_tx_len_meter.
module tb_tm_tx_len_meter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_begin, tx_commit, tx_abort, inst_retire, len_ready;
  logic [7:0] CurTxLen;
  logic       len_valid, in_tx, len_sat;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tm_tx_len_meter dut (
    .clk         (clk),
    .reset       (reset),
    .tx_begin    (tx_begin),
    .tx_commit   (tx_commit),
    .tx_abort    (tx_abort),
    .inst_retire (inst_retire),
    .len_ready   (len_ready),
    .CurTxLen    (CurTxLen),
    .len_valid   (len_valid),
    .in_tx       (in_tx),
    .len_sat     (len_sat),
    .drop_cnt    (drop_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_n(input int n);
    inst_retire = 1'b1;
    repeat (n) cyc();
    inst_retire = 1'b0;
  endtask

  // begin (no retire), n retires, commit with optional retire in commit cycle
  task automatic tx_run(input int n, input logic last_retire);
    tx_begin = 1'b1; cyc(); tx_begin = 1'b0;
    retire_n(n);
    tx_commit = 1'b1; inst_retire = last_retire; cyc();
    tx_commit = 1'b0; inst_retire = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_begin = 0; tx_commit = 0; tx_abort = 0; inst_retire = 0; len_ready = 0;
    cyc(); cyc();
    checks++;
    if ({CurTxLen, len_valid, in_tx, len_sat, drop_cnt} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got len=%0d v=%0b in_tx=%0b sat=%0b drop=%0d want all 0",
                         CurTxLen, len_valid, in_tx, len_sat, drop_cnt);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    len_ready = 1'b1;
    tx_begin = 1'b1; cyc(); tx_begin = 1'b0;
    checks++;
    if (in_tx !== 1'b1) begin errors++; $display("FAIL in_tx_after_begin: got %0b want 1", in_tx); end
    retire_n(64);
    tx_commit = 1'b1; cyc(); tx_commit = 1'b0;
    checks++;
    if (CurTxLen !== 8'd64 || len_valid !== 1'b1) begin
      errors++; $display("FAIL basic_len: got %0d v=%0b want 64 v=1", CurTxLen, len_valid);
    end
    checks++;
    if (in_tx !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL basic_state: got in_tx=%0b drop=%0d want 0 0", in_tx, drop_cnt);
    end
    cyc();
    checks++;
    if (len_valid !== 1'b0 || CurTxLen !== 8'd64) begin
      errors++; $display("FAIL basic_drain: got v=%0b len=%0d want v=0 len=64", len_valid, CurTxLen);
    end
  endtask

  task automatic test_saturate();
    checks++;
    if (len_sat !== 1'b0) begin errors++; $display("FAIL sat_pre: got %0b want 0", len_sat); end
    tx_run(300, 1'b0);
    checks++;
    if (CurTxLen !== 8'd255 || len_sat !== 1'b1 || len_valid !== 1'b1) begin
      errors++; $display("FAIL sat_len: got %0d sat=%0b v=%0b want 255 1 1", CurTxLen, len_sat, len_valid);
    end
    cyc();
  endtask

  task automatic test_abort();
    tx_begin = 1'b1; cyc(); tx_begin = 1'b0;
    retire_n(10);
    tx_abort = 1'b1; tx_commit = 1'b1; cyc(); tx_abort = 1'b0; tx_commit = 1'b0;
    checks++;
    if (len_valid !== 1'b0 || in_tx !== 1'b0) begin
      errors++; $display("FAIL abort_commit: got v=%0b in_tx=%0b want 0 0", len_valid, in_tx);
    end
    tx_run(5, 1'b0);
    checks++;
    if (CurTxLen !== 8'd5 || len_valid !== 1'b1 || len_sat !== 1'b1) begin
      errors++; $display("FAIL after_abort: got %0d v=%0b sat=%0b want 5 1 1", CurTxLen, len_valid, len_sat);
    end
    cyc();
  endtask

  task automatic test_drop();
    len_ready = 1'b0;
    tx_run(32, 1'b0);
    tx_run(7, 1'b0);
    checks++;
    if (CurTxLen !== 8'd32 || len_valid !== 1'b1 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL drop: got %0d v=%0b drop=%0d want 32 1 1", CurTxLen, len_valid, drop_cnt);
    end
    // zero-length commit against a full slot is not a drop
    tx_begin = 1'b1; cyc(); tx_begin = 1'b0;
    tx_commit = 1'b1; cyc(); tx_commit = 1'b0;
    checks++;
    if (drop_cnt !== 8'd1 || CurTxLen !== 8'd32) begin
      errors++; $display("FAIL zero_len: got drop=%0d len=%0d want 1 32", drop_cnt, CurTxLen);
    end
    len_ready = 1'b1; cyc();
    checks++;
    if (len_valid !== 1'b0 || CurTxLen !== 8'd32) begin
      errors++; $display("FAIL drop_drain: got v=%0b len=%0d want 0 32", len_valid, CurTxLen);
    end
  endtask

  task automatic test_back_to_back();
    len_ready = 1'b0;
    tx_run(77, 1'b0);
    checks++;
    if (CurTxLen !== 8'd77 || len_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_hold: got %0d v=%0b want 77 1", CurTxLen, len_valid);
    end
    tx_begin = 1'b1; cyc(); tx_begin = 1'b0;
    retire_n(19);
    // commit-cycle retire brings the length to 20; drain on the same edge
    tx_commit = 1'b1; inst_retire = 1'b1; len_ready = 1'b1; cyc();
    tx_commit = 1'b0; inst_retire = 1'b0; len_ready = 1'b0;
    checks++;
    if (CurTxLen !== 8'd20 || len_valid !== 1'b1 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL b2b_load: got %0d v=%0b drop=%0d want 20 1 1", CurTxLen, len_valid, drop_cnt);
    end
    len_ready = 1'b1; cyc();
  endtask

  task automatic test_edge_cases();
    // begin+commit in IDLE: begin wins; retire in begin cycle counts
    tx_begin = 1'b1; tx_commit = 1'b1; inst_retire = 1'b1; cyc();
    tx_begin = 1'b0; tx_commit = 1'b0;
    checks++;
    if (in_tx !== 1'b1 || len_valid !== 1'b0) begin
      errors++; $display("FAIL idle_begin_commit: got in_tx=%0b v=%0b want 1 0", in_tx, len_valid);
    end
    retire_n(2);
    // nested begin in ACTIVE does not restart the count; commit wins over begin
    tx_begin = 1'b1; cyc(); tx_begin = 1'b0;
    tx_commit = 1'b1; tx_begin = 1'b1; cyc(); tx_commit = 1'b0; tx_begin = 1'b0;
    checks++;
    if (CurTxLen !== 8'd3 || len_valid !== 1'b1 || in_tx !== 1'b0) begin
      errors++; $display("FAIL nested_commit: got %0d v=%0b in_tx=%0b want 3 1 0", CurTxLen, len_valid, in_tx);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    len_ready = 1'b0;
    tx_run(9, 1'b0);
    tx_begin = 1'b1; cyc(); tx_begin = 1'b0;
    retire_n(4);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({CurTxLen, len_valid, in_tx, len_sat, drop_cnt} !== 19'd0) begin
      errors++; $display("FAIL reset_async: got len=%0d v=%0b in_tx=%0b sat=%0b drop=%0d want all 0",
                         CurTxLen, len_valid, in_tx, len_sat, drop_cnt);
    end
    cyc();
    reset = 1'b1;
    tx_commit = 1'b1; inst_retire = 1'b1; cyc(); tx_commit = 1'b0; inst_retire = 1'b0;
    checks++;
    if (len_valid !== 1'b0 || in_tx !== 1'b0 || CurTxLen !== 8'd0) begin
      errors++; $display("FAIL commit_no_begin: got v=%0b in_tx=%0b len=%0d want 0 0 0", len_valid, in_tx, CurTxLen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_abort();
    test_drop();
    test_back_to_back();
    test_edge_cases();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tm_tx_len_meter
